// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cache_pkg;

    // Controller state: idle, load-miss fill, store write-through.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } cache_state_t;

    // Index bits select one of num_sets one-word lines.
    function automatic int idx_width(input int num_sets);
        return $clog2(num_sets);
    endfunction

    // Tag is everything above the index; the two byte-offset bits are dropped.
    function automatic int tag_width(input int addr_width, input int num_sets);
        return addr_width - 2 - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line storage (valid, tag, data) for the direct-mapped cache.
// Latency: combinational read by index; writes land on the rising edge.
// Backpressure: none; a write is accepted whenever wr_en is high.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset (clears valid bits)
//   rd_idx              read index
//   rd_vld/rd_tag/rd_dat line contents at rd_idx
//   wr_en/wr_idx        write strobe and index; the written line becomes valid
//   wr_tag/wr_dat       tag and data written
module cache_line_array
    import cache_pkg::*;
#(
    parameter int Data_Width = 32,
    parameter int Addr_Width = 32,
    parameter int Num_Sets   = 8,
    localparam int Idx_Width = idx_width(Num_Sets),
    localparam int Tag_Width = tag_width(Addr_Width, Num_Sets)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [Idx_Width-1:0]  rd_idx,
    output logic                  rd_vld,
    output logic [Tag_Width-1:0]  rd_tag,
    output logic [Data_Width-1:0] rd_dat,
    input  logic                  wr_en,
    input  logic [Idx_Width-1:0]  wr_idx,
    input  logic [Tag_Width-1:0]  wr_tag,
    input  logic [Data_Width-1:0] wr_dat
);

    logic [Num_Sets-1:0]   valid;
    logic [Tag_Width-1:0]  tag_mem  [Num_Sets];
    logic [Data_Width-1:0] data_mem [Num_Sets];

    // Reset only needs to clear the valid bits; tag/data contents are don't-care
    // until a line is filled.  Reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_dat;
        end
    end

    assign rd_vld = valid[rd_idx];
    assign rd_tag = tag_mem[rd_idx];
    assign rd_dat = data_mem[rd_idx];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Latency: load hit 0 cycles; load miss / store stall N+1 cycles for an ack on the Nth request cycle.
// Backpressure: Stall holds the datapath; backing memory is req/ack, one request outstanding.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   MemRead/MemWrite           load/store request (store wins when both are high)
//   Addr/WriteData             byte address (bits [1:0] ignored) and store data
//   ReadData                   load result, 0 unless an idle-state load hits
//   Stall                      datapath must hold its request while high
//   MemReq/MemWe/MemAddr/MemWData   backing-memory request, driven from state
//   MemRData/MemAck            backing-memory read data and one-cycle completion
//   HitCount/MissCount         present only when CACHE_STATS_EN is defined
module data_cache_ctrl
    import cache_pkg::*;
#(
    parameter int Data_Width = 32,
    parameter int Addr_Width = 32,
    parameter int Num_Sets   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [Addr_Width-1:0] Addr,
    input  logic [Data_Width-1:0] WriteData,
    output logic [Data_Width-1:0] ReadData,
    output logic                  Stall,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [Addr_Width-1:0] MemAddr,
    output logic [Data_Width-1:0] MemWData,
    input  logic [Data_Width-1:0] MemRData,
    input  logic                  MemAck
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           HitCount,
    output logic [31:0]           MissCount
`endif
);

    localparam int Idx_Width = idx_width(Num_Sets);
    localparam int Tag_Width = tag_width(Addr_Width, Num_Sets);

    cache_state_t state, state_nxt;

    logic [Idx_Width-1:0]  idx;
    logic [Tag_Width-1:0]  tag;
    logic                  line_vld;
    logic [Tag_Width-1:0]  line_tag;
    logic [Data_Width-1:0] line_dat;
    logic                  hit;
    logic                  line_we;
    logic [Data_Width-1:0] line_wdat;
    logic                  xact_done;
    logic                  load_req;
    logic                  store_req;
    logic                  addr_lsb_unused;

    assign idx             = Addr[2 +: Idx_Width];
    assign tag             = Addr[Addr_Width-1 -: Tag_Width];
    assign addr_lsb_unused = ^Addr[1:0];
    assign hit             = line_vld && (line_tag == tag);

    // The datapath keeps its request asserted in the cycle right after an ack
    // (Stall has only just fallen).  xact_done marks that cycle so the held
    // store is not issued a second time and the held load is not counted twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            xact_done <= 1'b0;
        end else begin
            xact_done <= (state != IDLE) && MemAck;
        end
    end

    assign store_req = MemWrite && !xact_done;
    assign load_req  = MemRead && !MemWrite;

    // Fill writes the whole line; a store only touches a line it already owns.
    assign line_we   = !rst && MemAck &&
                       ((state == FILL) || ((state == WRITE) && hit));
    assign line_wdat = (state == FILL) ? MemRData : WriteData;

    cache_line_array #(
        .Data_Width (Data_Width),
        .Addr_Width (Addr_Width),
        .Num_Sets   (Num_Sets)
    ) u_lines (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (idx),
        .rd_vld (line_vld),
        .rd_tag (line_tag),
        .rd_dat (line_dat),
        .wr_en  (line_we),
        .wr_idx (idx),
        .wr_tag (tag),
        .wr_dat (line_wdat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (store_req) begin
                    state_nxt = WRITE;
                end else if (load_req && !hit) begin
                    state_nxt = FILL;
                end
            end
            FILL, WRITE: begin
                if (MemAck) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs.  Memory-side signals decode the state register only; Addr and
    // WriteData pass through because the datapath holds them while stalled.
    always_comb begin
        MemReq   = 1'b0;
        MemWe    = 1'b0;
        MemAddr  = '0;
        MemWData = '0;
        Stall    = 1'b0;
        ReadData = '0;
        case (state)
            IDLE: begin
                Stall = store_req || (load_req && !hit);
                if (load_req && hit) begin
                    ReadData = line_dat;
                end
            end
            FILL: begin
                MemReq  = 1'b1;
                MemAddr = {Addr[Addr_Width-1:2], 2'b00};
                Stall   = 1'b1;
            end
            WRITE: begin
                MemReq   = 1'b1;
                MemWe    = 1'b1;
                MemAddr  = {Addr[Addr_Width-1:2], 2'b00};
                MemWData = WriteData;
                Stall    = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            Stall    = 1'b0;
            ReadData = '0;
        end
    end

`ifdef CACHE_STATS_EN
    // One count per request: the post-fill hit cycle belongs to the miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            HitCount  <= '0;
            MissCount <= '0;
        end else begin
            if ((state == IDLE) && load_req && hit && !xact_done) begin
                HitCount <= HitCount + 32'd1;
            end
            if ((state == IDLE) && (state_nxt == FILL)) begin
                MissCount <= MissCount + 32'd1;
            end
        end
    end
`endif

endmodule
